icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped, one-word-per-line instruction cache between the IF stage and memctrl.
//  - Hits return the instruction one cycle after the request.
//  - Misses fetch four bytes serially through memctrl's byte port, assemble them little-endian, fill the line, then respond.
//  - Cuts IF stalls on loops and frees memctrl bandwidth for the MEM stage.
// PARAMETERS
//  INDEX_W  7   index bits; 2**INDEX_W lines; tag = addr[16:2+INDEX_W]
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-low reset (0 = reset)
//  rdy        in   1   0 = freeze all state and hold all outputs
//  clear      in   1   abort outstanding request (pipeline redirect)
//  req_i      in   1   IF requests the instruction at addr_i
//  addr_i     in   32  fetch address; bits [1:0] and [31:18] ignored
//  ready_o    out  1   one-cycle pulse: inst_o valid for the latched address
//  inst_o     out  32  instruction word
//  mc_flag_o  out  1   byte read request to memctrl
//  mc_addr_o  out  32  byte address to memctrl
//  mc_r_i     in   1   memctrl returns the requested byte this cycle
//  mc_data_i  in   8   returned byte
// BEHAVIOUR
//  Reset values (async, rst=0):
//  - All valid bits 0; state IDLE; byte count 0.
//  - ready_o, mc_flag_o 0; inst_o, mc_addr_o 32'h0.
//  IDLE:
//  - On req_i, latch {addr_i[17:2],2'b00}; the cache sends no acknowledge.
//  - Tag match and valid -> HIT. Otherwise, or if addr[17:16]==2'b11 (I/O) -> FETCH.
//  HIT:
//  - ready_o=1 and inst_o=line data for one cycle, then IDLE.
//  - Latency is 1 cycle after the req_i sample.
//  FETCH:
//  - mc_flag_o=1 and mc_addr_o=base+cnt, held stable until mc_r_i.
//  - On mc_r_i: byte cnt -> inst[8*cnt+7:8*cnt]; cnt++.
//  - After byte 3, go to RESP. mc_flag_o drops in the same cycle as the final mc_r_i.
//  RESP:
//  - Write tag/data and set valid (skipped for I/O addresses).
//  - ready_o=1 for one cycle, then IDLE.
//  - Miss latency is 4 byte transfers plus 1 cycle.
//  Handshake and timing rules:
//  - req_i is sampled only in IDLE. IF holds req_i and addr_i until ready_o.
//  - A new req_i is accepted in the cycle after ready_o, not in the ready_o cycle.
//  - mc_r_i outside FETCH is ignored.
//  clear:
//  - Any state -> IDLE next cycle; mc_flag_o=0; cnt=0.
//  - No fill, no ready_o.
//  - If clear coincides with the 4th mc_r_i, clear wins: no fill, no response.
//  - clear in IDLE with req_i: the request is dropped.
//  rdy=0:
//  - Every register holds, including the valid array and cnt.
//  - mc_r_i is ignored; memctrl holds under the same rdy.
//  - Outputs keep their values.
//  Address wrap:
//  - base+cnt never carries past bit 1, because base is word-aligned.
//  - Index is addr[INDEX_W+1:2].
//  Reset mid-fetch: the partial word is discarded, and no line becomes valid.
// CONFIGURATION
//  ICACHE_PERF_EN defined:
//  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], each reset to 0.
//  - HIT entry increments hit_cnt_o; FETCH entry increments miss_cnt_o.
//  - Both counters saturate at 32'hFFFFFFFF and hold under rdy=0.
//  ICACHE_PERF_EN undefined: the counters and ports are absent; behaviour is otherwise identical.
// TESTING
//  1 Cold miss: req 0x0000_0104; memctrl returns bytes 13,05,00,00 at 0x104..0x107 -> ready_o pulse, inst_o=32'h00000513.
//  2 Hit: repeat 1 -> ready_o the next cycle, inst_o=32'h00000513, mc_flag_o stays 0.
//  3 Conflict: req 0x104+(4<<INDEX_W) misses, fills, evicts; re-req 0x104 -> misses again.
//  4 Clear mid-fetch: clear after 2 bytes -> IDLE, no ready_o; re-req 0x104 -> 4-byte fetch restarts at 0x104.
//  5 rdy=0 for 5 cycles during FETCH -> mc_addr_o and cnt frozen; resumes and completes with the correct word.
//  6 I/O addr 0x30000: fetch completes with ready_o, line not filled; repeat -> misses again.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and memctrl's byte port.
// Optional ICACHE_PERF_EN adds saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module icache #(
  parameter int INDEX_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        ready_o,
  output logic [31:0] inst_o,
  output logic        mc_flag_o,
  output logic [31:0] mc_addr_o,
  input  logic        mc_r_i,
  input  logic [7:0]  mc_data_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 15 - INDEX_W;

  typedef enum logic [1:0] {IDLE, HIT, FETCH, RESP} state_t;

  // latched request: word address addr[17:2]
  typedef struct packed {
    logic [15:0] wa;
  } req_t;

  state_t             state;
  req_t               req_q;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];
  logic [1:0]         cnt;
  logic [23:0]        fill_buf;

  logic [INDEX_W-1:0] idx_i, idx_q;
  logic [TAG_W-1:0]   tag_i, tag_q;
  logic               io_i, io_q, lookup_hit, fill_en;

  assign idx_i      = addr_i[INDEX_W+1:2];
  assign tag_i      = addr_i[16:2+INDEX_W];
  assign io_i       = (addr_i[17:16] == 2'b11);
  assign lookup_hit = valid[idx_i] && (tag_mem[idx_i] == tag_i) && !io_i;

  assign idx_q   = req_q.wa[INDEX_W-1:0];
  assign tag_q   = req_q.wa[14:INDEX_W];
  assign io_q    = (req_q.wa[15:14] == 2'b11);
  // I/O words are never cached; clear in the RESP cycle also suppresses the fill
  assign fill_en = rdy && !clear && (state == RESP) && !io_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_q     <= '0;
      valid     <= '0;
      cnt       <= 2'd0;
      fill_buf  <= '0;
      ready_o   <= 1'b0;
      inst_o    <= 32'h0;
      mc_flag_o <= 1'b0;
      mc_addr_o <= 32'h0;
`ifdef ICACHE_PERF_EN
      hit_cnt_o  <= 32'h0;
      miss_cnt_o <= 32'h0;
`endif
    end else if (rdy) begin
      if (clear) begin
        state     <= IDLE;
        cnt       <= 2'd0;
        ready_o   <= 1'b0;
        mc_flag_o <= 1'b0;
      end else begin
        case (state)
          IDLE: if (req_i) begin
            req_q.wa <= addr_i[17:2];
            if (lookup_hit) begin
              state   <= HIT;
              ready_o <= 1'b1;
              inst_o  <= data_mem[idx_i];
`ifdef ICACHE_PERF_EN
              if (hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
`endif
            end else begin
              state     <= FETCH;
              cnt       <= 2'd0;
              mc_flag_o <= 1'b1;
              mc_addr_o <= {14'h0, addr_i[17:2], 2'b00};
`ifdef ICACHE_PERF_EN
              if (miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
`endif
            end
          end
          HIT: begin
            ready_o <= 1'b0;
            state   <= IDLE;
          end
          FETCH: if (mc_r_i) begin
            if (cnt == 2'd3) begin
              inst_o    <= {mc_data_i, fill_buf};
              ready_o   <= 1'b1;
              mc_flag_o <= 1'b0;
              cnt       <= 2'd0;
              state     <= RESP;
            end else begin
              fill_buf[{cnt, 3'b000} +: 8] <= mc_data_i;
              cnt            <= cnt + 2'd1;
              mc_addr_o[1:0] <= cnt + 2'd1;
            end
          end
          RESP: begin
            if (!io_q) valid[idx_q] <= 1'b1;
            ready_o <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx_q]  <= tag_q;
      data_mem[idx_q] <= inst_o;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache: reference cache model + behavioural memctrl.
module tb_icache;
  logic        clk = 1'b0;
  logic        rst, rdy, clear, req_i, ready_o, mc_flag_o, mc_r_i;
  logic [31:0] addr_i, inst_o, mc_addr_o;
  logic [7:0]  mc_data_i;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  always #5 clk = ~clk;

  icache #(.INDEX_W(7)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .req_i(req_i), .addr_i(addr_i),
    .ready_o(ready_o), .inst_o(inst_o), .mc_flag_o(mc_flag_o), .mc_addr_o(mc_addr_o),
    .mc_r_i(mc_r_i), .mc_data_i(mc_data_i)
`ifdef ICACHE_PERF_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] sb_q[$];
  logic [31:0] mon_exp;

  // reference cache: 128 lines, tag = addr[16:9], index = addr[8:2]
  bit          m_valid [128];
  logic [7:0]  m_tag   [128];
  logic [31:0] m_data  [128];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] membyte(input logic [31:0] a);
    logic [7:0] h;
    case (a)
      32'h104: h = 8'h13;
      32'h105: h = 8'h05;
      32'h106, 32'h107: h = 8'h00;
      default: h = (a[7:0] * 8'd29) ^ a[15:8] ^ ({6'h0, a[17:16]} * 8'd77) ^ 8'hA5;
    endcase
    return h;
  endfunction

  function automatic logic [31:0] memword(input logic [31:0] b);
    return {membyte(b + 32'd3), membyte(b + 32'd2), membyte(b + 32'd1), membyte(b)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // scoreboard monitor: every ready_o pulse consumes one expected word
  always @(negedge clk) begin
    if (rst && rdy && ready_o) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_ready: inst %08h with nothing expected at %0t", inst_o, $time);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("inst", inst_o, mon_exp);
      end
    end
  end

  // One IF request. On a miss, clear_at/reset_at abort after that many bytes and
  // freeze_at stalls rdy for 5 cycles; all three are ignored on a predicted hit.
  task automatic do_req(input logic [31:0] a, input int clear_at, input bit clear_with_byte,
                        input int freeze_at, input int reset_at);
    logic [31:0] base, expw;
    logic [6:0]  idx;
    logic [7:0]  tg;
    bit          io, hit, aborted, got, frozen, lastr, done;
    int          n, bytes;
    base  = {14'h0, a[17:2], 2'b00};
    idx   = a[8:2];
    tg    = a[16:9];
    io    = (a[17:16] == 2'b11);
    hit   = !io && m_valid[idx] && (m_tag[idx] == tg);
    expw  = hit ? m_data[idx] : memword(base);
    aborted = !hit && (clear_at >= 0 || reset_at >= 0);
    if (!aborted) sb_q.push_back(expw);
    req_i = 1'b1; addr_i = a;
    n = 0; bytes = 0; got = 0; frozen = 0; lastr = 0; done = 0;
    while (n < 300 && !got && !done) begin
      tick(); n++;
      lastr = mc_r_i;
      mc_r_i = 1'b0; clear = 1'b0;
      if (ready_o) begin
        got = 1; req_i = 1'b0;
      end else if (mc_flag_o && !hit) begin
        if (freeze_at == bytes && !frozen) begin
          frozen = 1; rdy = 1'b0;
          for (int k = 0; k < 5; k++) begin
            mc_r_i = 1'b1; mc_data_i = 8'hEE;
            tick();
            chk("frz_addr", mc_addr_o, base + 32'(bytes));
            chk("frz_flag", {31'h0, mc_flag_o}, 32'h1);
          end
          rdy = 1'b1; mc_r_i = 1'b0;
        end
        if (clear_at == bytes) begin
          clear = 1'b1; req_i = 1'b0;
          if (clear_with_byte) begin mc_r_i = 1'b1; mc_data_i = membyte(mc_addr_o); end
          tick();
          clear = 1'b0; mc_r_i = 1'b0;
          for (int k = 0; k < 3; k++) begin
            chk("clr_flag", {31'h0, mc_flag_o}, 32'h0);
            chk("clr_ready", {31'h0, ready_o}, 32'h0);
            tick();
          end
          done = 1;
        end else if (reset_at == bytes) begin
          rst = 1'b0; req_i = 1'b0;
          tick();
          chk("rst_flag", {31'h0, mc_flag_o}, 32'h0);
          chk("rst_ready", {31'h0, ready_o}, 32'h0);
          rst = 1'b1; model_reset();
          tick();
          done = 1;
        end else begin
          chk("mc_addr", mc_addr_o, base + 32'(bytes));
          if ($urandom_range(0, 2) != 0) begin
            mc_r_i = 1'b1; mc_data_i = membyte(mc_addr_o); bytes++;
          end
        end
      end
    end
    if (!aborted) begin
      chk("resp_seen", {31'h0, got}, 32'h1);
      if (got) begin
        if (hit) chk("hit_lat", 32'(n), 32'd1);
        else begin
          chk("miss_bytes", 32'(bytes), 32'd4);
          chk("miss_lat", {31'h0, lastr}, 32'h1);
          if (!io) begin m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = expw; end
        end
      end
      req_i = 1'b0; mc_r_i = 1'b0;
      tick();
    end
  endtask

  task automatic idle_clear(input logic [31:0] a);
    req_i = 1'b1; addr_i = a; clear = 1'b1;
    tick();
    req_i = 1'b0; clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("drop_flag", {31'h0, mc_flag_o}, 32'h0);
      chk("drop_ready", {31'h0, ready_o}, 32'h0);
      tick();
    end
  endtask

  initial begin
    logic [31:0] a;
    int ca, fa, ra;
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; req_i = 1'b0; addr_i = 32'h0;
    mc_r_i = 1'b0; mc_data_i = 8'h0;
    model_reset();
    repeat (3) tick();
    chk("rst_ready_o", {31'h0, ready_o}, 32'h0);
    chk("rst_mc_flag", {31'h0, mc_flag_o}, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_mc_addr", mc_addr_o, 32'h0);
    rst = 1'b1;
    tick();

    do_req(32'h0000_0104, -1, 0, -1, -1);     // cold miss -> 0x00000513
    do_req(32'h0000_0104, -1, 0, -1, -1);     // hit
    do_req(32'h0000_0304, -1, 0, -1, -1);     // conflict evicts
    do_req(32'h0000_0104, -1, 0, -1, -1);     // misses again
    do_req(32'h0000_0304, -1, 0, -1, -1);     // evict 0x104
    do_req(32'h0000_0104,  2, 0, -1, -1);     // clear after 2 bytes
    do_req(32'h0000_0104, -1, 0, -1, -1);     // refetch from 0x104
    do_req(32'h0000_0304,  3, 1, -1, -1);     // clear with 4th byte: no fill
    do_req(32'h0000_0104, -1, 0, -1, -1);     // still a hit
    do_req(32'h0000_2000, -1, 0,  2, -1);     // rdy stall mid-fetch
    do_req(32'h0003_0000, -1, 0, -1, -1);     // I/O: not cached
    do_req(32'h0003_0000, -1, 0, -1, -1);
    idle_clear(32'h0000_2000);                // request dropped
    do_req(32'h0000_2000, -1, 0, -1, -1);     // hit
    do_req(32'hFFFC_2003, -1, 0, -1, -1);     // ignored bits -> hit on 0x2000
    do_req(32'h0000_4000, -1, 0, -1,  2);     // reset mid-fetch
    do_req(32'h0000_0104, -1, 0, -1, -1);     // cache is cold again

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      a[8:2]   = 7'($urandom_range(0, 7));
      a[16:9]  = 8'($urandom_range(0, 2));
      a[17]    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) a[17:16] = 2'b11;
      ca = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      ra = (ca < 0 && $urandom_range(0, 29) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_req(a, ca, ($urandom_range(0, 1) == 1), fa, ra);
    end

    repeat (3) tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
